// File: rtl/modulo_counter_pkg.sv
// Shared types and helpers for the programmable modulo counter.
package modulo_counter_pkg;

  // Run mode; the spare encoding 2'd3 behaves as WRAP.
  typedef enum logic [1:0] {
    WRAP      = 2'd0,
    ONESHOT   = 2'd1,
    SAT       = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest width able to index value states; never less than 1.
  function automatic int unsigned CeilLog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/modcnt_terminal_decode.sv
// Start/terminal value decode and terminal-count compare for the latched settings.
module modcnt_terminal_decode
  import modulo_counter_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic [CNT_W:0]   modulus,
  input  logic             dir_up,
  input  logic             active,
  input  logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] start_val,
  output logic [CNT_W-1:0] term_val,
  output logic             tc
);

  logic [CNT_W-1:0] top_val;

  // Highest legal count for this modulus; modulus is never 0 here, so no underflow.
  always_comb begin
    top_val   = CNT_W'(modulus - 1'b1);
    start_val = dir_up ? '0 : top_val;
    term_val  = dir_up ? top_val : '0;
    tc        = active && (count == term_val);
  end

endmodule

// File: rtl/modulo_counter_prog.sv
// Programmable-modulus up/down counter with wrap, one-shot and saturate run modes.
module modulo_counter_prog
  import modulo_counter_pkg::*;
#(
  parameter int unsigned MAX_MODULUS = 36,
  parameter int unsigned CNT_W       = CeilLog2(MAX_MODULUS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [CNT_W:0]   modulus_in,
  input  logic [1:0]       mode_in,
  input  logic             dir_in,
  output logic [CNT_W-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             done,
  output logic             busy
);

  localparam logic [CNT_W:0] MaxMod = (CNT_W + 1)'(MAX_MODULUS);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W:0]   mod_q, mod_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  logic [CNT_W-1:0] start_val, term_val;
  logic [CNT_W:0]   mod_map;
  logic [CNT_W-1:0] new_start;

  modcnt_terminal_decode #(
    .CNT_W (CNT_W)
  ) u_decode (
    .modulus   (mod_q),
    .dir_up    (dir_q),
    .active    (state_q != IDLE),
    .count     (count_q),
    .start_val (start_val),
    .term_val  (term_val),
    .tc        (tc)
  );

  // Start value for the settings being requested on this cycle's inputs.
  always_comb begin
    mod_map   = ((modulus_in == '0) || (modulus_in > MaxMod)) ? MaxMod : modulus_in;
    new_start = dir_in ? '0 : CNT_W'(mod_map - 1'b1);
  end

  // Next-state: clear > stop > start > enable.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mod_d   = mod_q;
    dir_d   = dir_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = start_val;
    end else if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      mod_d   = mod_map;
      mode_d  = (mode_in == 2'd3) ? WRAP : mode_e'(mode_in);
      dir_d   = dir_in;
      count_d = new_start;
      state_d = RUN;
    end else if ((state_q == RUN) && enable) begin
      if (count_q != term_val) begin
        count_d = dir_q ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
      end else begin
        case (mode_q)
          ONESHOT: begin
            state_d = DONE;
            wrap_d  = 1'b1;
          end
          SAT:     ;
          default: begin
            count_d = start_val;
            wrap_d  = 1'b1;
          end
        endcase
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= WRAP;
      mod_q   <= MaxMod;
      dir_q   <= 1'b1;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mod_q   <= mod_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count      = count_q;
  assign wrap_pulse = wrap_q;
  assign done       = (state_q == DONE);
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_modulo_counter_prog.sv
module tb_modulo_counter_prog;

  localparam int unsigned CW = 6;

  typedef struct packed {
    logic [CW-1:0] count;
    logic          tc;
    logic          wrap;
    logic          done;
    logic          busy;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable, start, stop, clear, dir_in;
  logic [CW:0]   modulus_in;
  logic [1:0]    mode_in;
  logic [CW-1:0] count;
  logic          tc, wrap_pulse, done, busy;
  obs_t          observed;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;

  modulo_counter_prog #(
    .MAX_MODULUS (36)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .modulus_in (modulus_in),
    .mode_in    (mode_in),
    .dir_in     (dir_in),
    .count      (count),
    .tc         (tc),
    .wrap_pulse (wrap_pulse),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign observed = {count, tc, wrap_pulse, done, busy};

  function automatic obs_t o(input int c, input logic t, input logic w, input logic d,
                             input logic b);
    obs_t r;
    r.count = CW'(c);
    r.tc    = t;
    r.wrap  = w;
    r.done  = d;
    r.busy  = b;
    return r;
  endfunction

  task automatic drive(input logic st, input logic sp, input logic cl, input logic en,
                       input int m, input logic [1:0] md, input logic d);
    start      = st;
    stop       = sp;
    clear      = cl;
    enable     = en;
    modulus_in = (CW + 1)'(m);
    mode_in    = md;
    dir_in     = d;
  endtask

  task automatic compare_head();
    obs_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_checks++;
    assert (observed === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed count=%0d tc=%b wrap=%b done=%b busy=%b, expected count=%0d tc=%b wrap=%b done=%b busy=%b",
             t, observed.count, observed.tc, observed.wrap, observed.done, observed.busy,
             e.count, e.tc, e.wrap, e.done, e.busy);
    end
  endtask

  // Expectation for the state after the next rising edge.
  task automatic step(input string tag, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  // Expectation for the present state, no clock edge.
  task automatic now(input string tag, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    compare_head();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 2'd0, 1'b1);
    #2;
    now("reset", o(0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // WRAP, up, modulus 5
    drive(1, 0, 0, 1, 5, 2'd0, 1'b1);
    step("wrap_start", o(0, 0, 0, 0, 1));
    drive(0, 0, 0, 1, 0, 2'd2, 1'b0);
    step("wrap_c1", o(1, 0, 0, 0, 1));
    step("wrap_c2", o(2, 0, 0, 0, 1));
    step("wrap_c3", o(3, 0, 0, 0, 1));
    step("wrap_c4_tc", o(4, 1, 0, 0, 1));
    step("wrap_c0_pulse", o(0, 0, 1, 0, 1));
    step("wrap_c1_again", o(1, 0, 0, 0, 1));
    drive(0, 0, 0, 0, 0, 2'd0, 1'b0);
    step("wrap_hold", o(1, 0, 0, 0, 1));

    // ONESHOT, down, modulus 4
    drive(1, 0, 0, 1, 4, 2'd1, 1'b0);
    step("os_start", o(3, 0, 0, 0, 1));
    drive(0, 0, 0, 1, 9, 2'd0, 1'b1);
    step("os_c2", o(2, 0, 0, 0, 1));
    step("os_c1", o(1, 0, 0, 0, 1));
    step("os_c0_tc", o(0, 1, 0, 0, 1));
    step("os_done", o(0, 1, 1, 1, 0));
    step("os_done_hold", o(0, 1, 0, 1, 0));
    drive(0, 0, 1, 1, 0, 2'd0, 1'b1);
    step("os_clear_in_done", o(3, 0, 0, 1, 0));
    drive(1, 0, 0, 0, 4, 2'd1, 1'b0);
    step("os_restart", o(3, 0, 0, 0, 1));

    // SAT, up, modulus 3
    drive(1, 0, 0, 1, 3, 2'd2, 1'b1);
    step("sat_start", o(0, 0, 0, 0, 1));
    drive(0, 0, 0, 1, 0, 2'd0, 1'b0);
    step("sat_c1", o(1, 0, 0, 0, 1));
    step("sat_c2", o(2, 1, 0, 0, 1));
    step("sat_hold1", o(2, 1, 0, 0, 1));
    step("sat_hold2", o(2, 1, 0, 0, 1));

    // Modulus 0 maps to 36
    drive(1, 0, 0, 1, 0, 2'd0, 1'b1);
    step("m0_start", o(0, 0, 0, 0, 1));
    drive(0, 0, 0, 1, 0, 2'd0, 1'b1);
    for (int i = 1; i <= 35; i++) step($sformatf("m0_c%0d", i), o(i, i == 35, 0, 0, 1));
    step("m0_wrap", o(0, 0, 1, 0, 1));

    // Modulus above range (41) maps to 36; mode 3 behaves as WRAP
    drive(1, 0, 0, 1, 41, 2'd3, 1'b1);
    step("m41_start", o(0, 0, 0, 0, 1));
    drive(0, 0, 0, 1, 0, 2'd0, 1'b1);
    for (int i = 1; i <= 35; i++) step($sformatf("m41_c%0d", i), o(i, i == 35, 0, 0, 1));
    step("m41_wrap", o(0, 0, 1, 0, 1));

    // Modulus 1: start equals terminal
    drive(1, 0, 0, 1, 1, 2'd0, 1'b1);
    step("m1_start", o(0, 1, 0, 0, 1));
    drive(0, 0, 0, 1, 0, 2'd0, 1'b1);
    step("m1_pulse1", o(0, 1, 1, 0, 1));
    step("m1_pulse2", o(0, 1, 1, 0, 1));
    drive(0, 0, 0, 0, 0, 2'd0, 1'b1);
    step("m1_idle_en", o(0, 1, 0, 0, 1));

    // clear + start: clear wins, settings not re-latched
    drive(1, 0, 0, 1, 5, 2'd0, 1'b1);
    step("cs_setup", o(0, 0, 0, 0, 1));
    drive(0, 0, 0, 1, 0, 2'd0, 1'b1);
    step("cs_c1", o(1, 0, 0, 0, 1));
    step("cs_c2", o(2, 0, 0, 0, 1));
    drive(1, 0, 1, 1, 3, 2'd1, 1'b0);
    step("cs_clear_wins", o(0, 0, 0, 0, 1));
    drive(0, 0, 0, 1, 0, 2'd0, 1'b0);
    step("cs_still_up_c1", o(1, 0, 0, 0, 1));
    step("cs_c2b", o(2, 0, 0, 0, 1));
    step("cs_c3", o(3, 0, 0, 0, 1));
    step("cs_c4", o(4, 1, 0, 0, 1));

    // stop + enable at terminal: IDLE, no pulse
    drive(0, 1, 0, 1, 0, 2'd0, 1'b0);
    step("stop_at_term", o(4, 0, 0, 0, 0));
    drive(0, 0, 0, 1, 0, 2'd0, 1'b0);
    step("idle_ignores_en", o(4, 0, 0, 0, 0));

    // Restart during RUN at count 2
    drive(1, 0, 0, 1, 5, 2'd0, 1'b1);
    step("rs_setup", o(0, 0, 0, 0, 1));
    drive(0, 0, 0, 1, 0, 2'd0, 1'b1);
    step("rs_c1", o(1, 0, 0, 0, 1));
    step("rs_c2", o(2, 0, 0, 0, 1));
    drive(1, 0, 0, 1, 6, 2'd0, 1'b0);
    step("rs_restart_down", o(5, 0, 0, 0, 1));
    drive(0, 0, 0, 1, 0, 2'd0, 1'b1);
    step("rs_c4", o(4, 0, 0, 0, 1));
    step("rs_c3", o(3, 0, 0, 0, 1));

    // Asynchronous reset mid-count, away from any clock edge
    drive(0, 0, 0, 0, 0, 2'd0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    now("async_reset", o(0, 0, 0, 0, 0));
    reset = 1'b0;
    drive(0, 0, 0, 1, 0, 2'd0, 1'b1);
    step("post_reset_idle", o(0, 0, 0, 0, 0));
    drive(1, 0, 0, 1, 5, 2'd0, 1'b1);
    step("post_reset_start", o(0, 0, 0, 0, 1));
    drive(0, 0, 0, 1, 0, 2'd0, 1'b1);
    step("post_reset_c1", o(1, 0, 0, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
